frame_buf_arb: RTL and testbench
================================

Name: frame_buf_arb

Overview:
Two-port arbiter and sequencer in front of the frame-buffer data memory (data_mem_alt-style slave with active-low wr_en/rd_en).
- Shares the single memory between a pixel-writer requester and a display-reader requester.
- Guarantees that memory write and read enables are never asserted together.
- Holds each command on the memory bus for a fixed number of cycles, then returns a one-cycle ack (and read data) to the requester.

Parameters:
DATA_WIDTH, 32, width of pixel data words
ADDR_WIDTH, 29, width of memory word address
CMD_CYCLES, 3, cycles a memory enable is held asserted per access; legal range >= 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_req  in  1  writer request, active-high, level
wr_req_addr  in  ADDR_WIDTH  write address, stable while wr_req high until wr_ack
wr_req_data  in  DATA_WIDTH  write data, stable with wr_req_addr
wr_ack  out  1  one-cycle pulse, write completed
rd_req  in  1  reader request, active-high, level
rd_req_addr  in  ADDR_WIDTH  read address, stable while rd_req high until rd_ack
rd_ack  out  1  one-cycle pulse, rd_resp_data valid this cycle
rd_resp_data  out  DATA_WIDTH  read data, held until next read completes
mem_wr_addr  out  ADDR_WIDTH  to memory wr_addr
mem_wr_data  out  DATA_WIDTH  to memory wr_data
mem_rd_addr  out  ADDR_WIDTH  to memory rd_addr
mem_wr_en  out  1  to memory wr_en, active-low
mem_rd_en  out  1  to memory rd_en, active-low
mem_rd_data  in  DATA_WIDTH  from memory rd_data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values, applied asynchronously while reset is low:
  - FSM = IDLE.
  - mem_wr_en = mem_rd_en = 1 (deasserted).
  - wr_ack = rd_ack = 0, busy = 0.
  - rd_resp_data, mem_wr_addr, mem_wr_data and mem_rd_addr all 0.
  - cycle counter = 0; last_grant = WRITE, so the first tie goes to read.
- All outputs are registered.
- FSM states: IDLE, WRITE, READ, RD_WAIT, ACK.
- IDLE: wr_req and rd_req are sampled only in this state.
  - Neither request high: stay in IDLE.
  - One request high: grant it.
  - Both high: grant the requester not in last_grant (round-robin).
  - On grant: latch the address (and data, for a write) onto the mem_* buses, load counter = CMD_CYCLES-1, update last_grant, go to WRITE or READ.
- WRITE: mem_wr_en = 0. Decrement the counter each cycle; at 0 go to ACK with wr_ack = 1.
- READ: mem_rd_en = 0. Same counting; at 0 go to RD_WAIT.
- RD_WAIT: both enables deasserted. Register mem_rd_data into rd_resp_data, go to ACK with rd_ack = 1.
- ACK: the ack is high for exactly this one cycle, then the FSM returns to IDLE.
  - The requester may drop its req, or present a new address/data, during the ack cycle.
  - If req is still high in the following IDLE cycle, that is a new transaction.
- Latency, with the request seen at edge 0:
  - Write: enable low in cycles 1..CMD_CYCLES; wr_ack in cycle CMD_CYCLES+1.
  - Read: rd_ack in cycle CMD_CYCLES+2.
  - Minimum back-to-back issue period = CMD_CYCLES+2 cycles (write) or CMD_CYCLES+3 cycles (read).
- Invariants:
  - mem_wr_en and mem_rd_en are never both 0.
  - An ack is never issued without a prior grant.
  - At most one ack per cycle.
- mem_* address and data buses hold their last values when idle; they change only at grant.
- Requests deasserted mid-transaction are ignored: the transaction completes and is acked.
- Reset asserted mid-transaction aborts it with no ack; the requester must reissue.

Optional Feature:
READ_PRIORITY_EN
- Defined: on a tie, rd_req always wins (display must not underrun); last_grant is still maintained but unused.
- Undefined: round-robin tie-break as above.
- Single-request behaviour is identical in both builds.

Decomposition:
- frame_buf_pkg holds:
  - FSM state encodings (IDLE/WRITE/READ/RD_WAIT/ACK).
  - GRANT_WR/GRANT_RD constants.
  - ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H constants.
- One sub-module, arb_rr2: two-way round-robin picker. Inputs are the two requests and last_grant; outputs are a one-hot grant. It also contains the READ_PRIORITY_EN branch.

Test Plan (CMD_CYCLES=3, DATA_WIDTH=32, ADDR_WIDTH=29; build without READ_PRIORITY_EN unless a line says otherwise):
- Single write, addr 0x10, data 0xDEADBEEF:
  - mem_wr_en low in cycles 1-3 with mem_wr_addr=0x10 and mem_wr_data=0xDEADBEEF.
  - wr_ack pulses in cycle 4; mem_rd_en stays 1 throughout.
- Write 0x10/0xDEADBEEF, then read 0x10: mem_rd_en low for 3 cycles, rd_ack pulses one cycle later with rd_resp_data=0xDEADBEEF.
- wr_req and rd_req raised together, held for 4 transactions with distinct addresses:
  - Grant order is R,W,R,W.
  - No cycle has both mem enables at 0.
- Same simultaneous stimulus with READ_PRIORITY_EN defined: all reads complete before any write is granted.
- reset driven low in cycle 2 of a write:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - No wr_ack; after release the FSM is in IDLE and a reissued write completes normally.
- Requester drops rd_req in cycle 1 of a read: the read still completes and rd_ack pulses exactly once.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the frame-buffer arbiter.
// READ_PRIORITY_EN (see arb_rr2) selects the tie-break policy.
package frame_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RD_WAIT,
    ST_ACK
  } fb_state_e;

  // One-hot grant: bit 0 = pixel writer, bit 1 = display reader
  typedef logic [1:0] grant_t;

  localparam grant_t GRANT_NONE = 2'b00;
  localparam grant_t GRANT_WR   = 2'b01;
  localparam grant_t GRANT_RD   = 2'b10;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/frame_buf_arb_if.sv
// Requester and memory-side signals of the frame-buffer arbiter.
// slave = the arbiter, master = requesters plus the memory.
interface frame_buf_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29
);

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_ack;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_resp_data;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  busy;

  modport slave (
    input  wr_req, wr_req_addr, wr_req_data, rd_req, rd_req_addr, mem_rd_data,
    output wr_ack, rd_ack, rd_resp_data, mem_wr_addr, mem_wr_data, mem_rd_addr,
           mem_wr_en, mem_rd_en, busy
  );

  modport master (
    output wr_req, wr_req_addr, wr_req_data, rd_req, rd_req_addr, mem_rd_data,
    input  wr_ack, rd_ack, rd_resp_data, mem_wr_addr, mem_wr_data, mem_rd_addr,
           mem_wr_en, mem_rd_en, busy
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way picker between the pixel writer and the display reader.
// Define READ_PRIORITY_EN to make reads always win a tie; otherwise round-robin.
module arb_rr2
  import frame_buf_pkg::*;
(
  input  logic   wr_req,
  input  logic   rd_req,
  input  grant_t last_grant,
  output grant_t grant
);

`ifdef READ_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  // On a tie the default build hands the bus to whoever did not have it last
  always_comb begin
    grant = GRANT_NONE;
    if (wr_req && rd_req) begin
`ifdef READ_PRIORITY_EN
      grant = GRANT_RD;
`else
      grant = (last_grant == GRANT_WR) ? GRANT_RD : GRANT_WR;
`endif
    end else if (wr_req) begin
      grant = GRANT_WR;
    end else if (rd_req) begin
      grant = GRANT_RD;
    end
  end

endmodule

// File: rtl/frame_buf_arb.sv
// Arbiter/sequencer sharing one frame-buffer memory between writer and reader.
// Tie-break policy is set in arb_rr2 by the READ_PRIORITY_EN macro.
module frame_buf_arb
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int CMD_CYCLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  frame_buf_arb_if.slave bus
);

  localparam int CNT_W = (CMD_CYCLES > 1) ? $clog2(CMD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CMD_CYCLES - 1);

  fb_state_e        state;
  logic [CNT_W-1:0] cnt;
  grant_t           last_grant;
  grant_t           grant;

  arb_rr2 u_arb (
    .wr_req     (bus.wr_req),
    .rd_req     (bus.rd_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Requests are only looked at in IDLE, so a grant always runs to its ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      last_grant       <= GRANT_WR;
      bus.mem_wr_en    <= DEASSERT_L;
      bus.mem_rd_en    <= DEASSERT_L;
      bus.wr_ack       <= DEASSERT_H;
      bus.rd_ack       <= DEASSERT_H;
      bus.busy         <= 1'b0;
      bus.rd_resp_data <= {DATA_WIDTH{1'b0}};
      bus.mem_wr_addr  <= {ADDR_WIDTH{1'b0}};
      bus.mem_wr_data  <= {DATA_WIDTH{1'b0}};
      bus.mem_rd_addr  <= {ADDR_WIDTH{1'b0}};
    end else begin
      bus.wr_ack <= DEASSERT_H;
      bus.rd_ack <= DEASSERT_H;
      case (state)
        ST_IDLE: begin
          if (grant == GRANT_WR) begin
            bus.mem_wr_addr <= bus.wr_req_addr;
            bus.mem_wr_data <= bus.wr_req_data;
            bus.mem_wr_en   <= ASSERT_L;
            cnt             <= CNT_LOAD;
            last_grant      <= GRANT_WR;
            bus.busy        <= 1'b1;
            state           <= ST_WRITE;
          end else if (grant == GRANT_RD) begin
            bus.mem_rd_addr <= bus.rd_req_addr;
            bus.mem_rd_en   <= ASSERT_L;
            cnt             <= CNT_LOAD;
            last_grant      <= GRANT_RD;
            bus.busy        <= 1'b1;
            state           <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (cnt == '0) begin
            bus.mem_wr_en <= DEASSERT_L;
            bus.wr_ack    <= ASSERT_H;
            state         <= ST_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_READ: begin
          if (cnt == '0) begin
            bus.mem_rd_en <= DEASSERT_L;
            state         <= ST_RD_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RD_WAIT: begin
          bus.rd_resp_data <= bus.mem_rd_data;
          bus.rd_ack       <= ASSERT_H;
          state            <= ST_ACK;
        end
        ST_ACK: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.mem_wr_en <= DEASSERT_L;
          bus.mem_rd_en <= DEASSERT_L;
          bus.busy      <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_arb.sv
// Bench for frame_buf_arb: memory stub, array reference model, scenario tasks.
// Build with READ_PRIORITY_EN defined to check the read-priority tie-break.
module tb_frame_buf_arb;
  import frame_buf_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 29;
  localparam int CMDC = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_buf_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fb ();

  frame_buf_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_CYCLES(CMDC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fb)
  );

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;
  int dual_ack_cnt = 0;

  // Addresses are kept below 64 so both arrays can be indexed directly
  logic [DW-1:0] stub_mem [64];
  logic [DW-1:0] ref_mem  [64];

  // Synchronous memory with active-low enables
  always @(posedge clk) begin
    if (fb.mem_wr_en == 1'b0) stub_mem[fb.mem_wr_addr[5:0]] <= fb.mem_wr_data;
    if (fb.mem_rd_en == 1'b0) fb.mem_rd_data <= stub_mem[fb.mem_rd_addr[5:0]];
  end

  always @(negedge clk) begin
    if (reset) begin
      if (fb.mem_wr_en === 1'b0 && fb.mem_rd_en === 1'b0) overlap_cnt++;
      if (fb.wr_ack === 1'b1 && fb.rd_ack === 1'b1) dual_ack_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output int en_cnt, output bit bus_ok);
    @(negedge clk);
    fb.wr_req = 1'b1; fb.wr_req_addr = a; fb.wr_req_data = d;
    lat = 0; en_cnt = 0; bus_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (fb.mem_wr_en === 1'b0) begin
        en_cnt++;
        if (fb.mem_wr_addr !== a || fb.mem_wr_data !== d) bus_ok = 1'b0;
      end
      if (fb.mem_rd_en !== 1'b1 || fb.busy !== 1'b1) bus_ok = 1'b0;
    end while (fb.wr_ack !== 1'b1 && lat < 40);
    fb.wr_req = 1'b0;
    if (fb.wr_ack === 1'b1) ref_mem[a[5:0]] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int lat, output int en_cnt,
                         output bit bus_ok, output logic [DW-1:0] data);
    @(negedge clk);
    fb.rd_req = 1'b1; fb.rd_req_addr = a;
    lat = 0; en_cnt = 0; bus_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (fb.mem_rd_en === 1'b0) begin
        en_cnt++;
        if (fb.mem_rd_addr !== a) bus_ok = 1'b0;
      end
      if (fb.mem_wr_en !== 1'b1 || fb.busy !== 1'b1) bus_ok = 1'b0;
    end while (fb.rd_ack !== 1'b1 && lat < 40);
    data = fb.rd_resp_data;
    fb.rd_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    checks++;
    if ({fb.mem_wr_en, fb.mem_rd_en} !== 2'b11) begin
      errors++; $display("[TB] FAIL reset_enables got %b want 11", {fb.mem_wr_en, fb.mem_rd_en});
    end
    checks++;
    if ({fb.wr_ack, fb.rd_ack, fb.busy} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_ack_busy got %b want 000", {fb.wr_ack, fb.rd_ack, fb.busy});
    end
    checks++;
    if (fb.rd_resp_data !== '0 || fb.mem_wr_addr !== '0 || fb.mem_wr_data !== '0 || fb.mem_rd_addr !== '0) begin
      errors++; $display("[TB] FAIL reset_buses got %h/%h/%h/%h want all 0",
                         fb.rd_resp_data, fb.mem_wr_addr, fb.mem_wr_data, fb.mem_rd_addr);
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (fb.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_busy got %b want 0", fb.busy);
    end
  endtask

  task automatic test_single_write;
    int lat, en; bit ok;
    do_write(29'h10, 32'hDEADBEEF, lat, en, ok);
    checks++;
    if (lat != CMDC + 1) begin
      errors++; $display("[TB] FAIL write_latency got %0d want %0d", lat, CMDC + 1);
    end
    checks++;
    if (en != CMDC) begin
      errors++; $display("[TB] FAIL write_en_cycles got %0d want %0d", en, CMDC);
    end
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL write_bus got bad addr/data/rd_en/busy want clean");
    end
    @(negedge clk);
    checks++;
    if ({fb.wr_ack, fb.busy, fb.mem_wr_en} !== 3'b001) begin
      errors++; $display("[TB] FAIL write_after_ack got %b want 001", {fb.wr_ack, fb.busy, fb.mem_wr_en});
    end
  endtask

  task automatic test_write_read;
    int lat, en; bit ok; logic [DW-1:0] d;
    do_read(29'h10, lat, en, ok, d);
    checks++;
    if (lat != CMDC + 2) begin
      errors++; $display("[TB] FAIL read_latency got %0d want %0d", lat, CMDC + 2);
    end
    checks++;
    if (en != CMDC || !ok) begin
      errors++; $display("[TB] FAIL read_bus got en_cycles %0d ok %0b want %0d 1", en, ok, CMDC);
    end
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL read_data got %h want deadbeef", d);
    end
    @(negedge clk);
    checks++;
    if (fb.rd_resp_data !== 32'hDEADBEEF || fb.rd_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL read_hold got %h ack %b want deadbeef 0", fb.rd_resp_data, fb.rd_ack);
    end
  endtask

  task automatic test_random;
    int lat, en; bit ok; logic [DW-1:0] d, exp_d; logic [AW-1:0] a;
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        do_write(a, d, lat, en, ok);
        checks++;
        if (lat != CMDC + 1 || en != CMDC || !ok) begin
          errors++; $display("[TB] FAIL rand_write lat %0d en %0d ok %0b want %0d %0d 1", lat, en, ok, CMDC + 1, CMDC);
        end
      end else begin
        exp_d = ref_mem[a[5:0]];
        do_read(a, lat, en, ok, d);
        checks++;
        if (lat != CMDC + 2 || en != CMDC || !ok || d !== exp_d) begin
          errors++; $display("[TB] FAIL rand_read addr %h got %h lat %0d en %0d ok %0b want %h lat %0d",
                             a, d, lat, en, ok, exp_d, CMDC + 2);
        end
      end
    end
  endtask

  task automatic test_tie;
    int lat, en; bit ok;
    logic [AW-1:0] ra [2];
    logic [AW-1:0] wa [2];
    logic [DW-1:0] wd [2];
    bit got_order [$];
    bit exp_order [$];
    int nw, nr, pw, pr, cyc;
    bit last_w, pick_r;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 2; i++) begin
      ra[i] = AW'(32 + i);
      wa[i] = AW'(40 + i);
      wd[i] = $urandom;
      do_write(ra[i], $urandom, lat, en, ok);
    end
    // Fresh reset puts the round-robin pointer back on the writer
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    pw = 2; pr = 2; last_w = 1'b1;
    while (pw > 0 || pr > 0) begin
`ifdef READ_PRIORITY_EN
      pick_r = (pr > 0);
`else
      pick_r = (pw > 0 && pr > 0) ? last_w : (pr > 0);
`endif
      exp_order.push_back(pick_r);
      if (pick_r) pr--; else pw--;
      last_w = !pick_r;
    end
    fb.wr_req = 1'b1; fb.wr_req_addr = wa[0]; fb.wr_req_data = wd[0];
    fb.rd_req = 1'b1; fb.rd_req_addr = ra[0];
    nw = 0; nr = 0; cyc = 0;
    while ((nw < 2 || nr < 2) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (fb.wr_ack === 1'b1) begin
        got_order.push_back(1'b0);
        ref_mem[wa[nw][5:0]] = wd[nw];
        nw++;
        if (nw < 2) begin fb.wr_req_addr = wa[nw]; fb.wr_req_data = wd[nw]; end
        else fb.wr_req = 1'b0;
      end
      if (fb.rd_ack === 1'b1) begin
        exp_d = ref_mem[ra[nr][5:0]];
        checks++;
        if (fb.rd_resp_data !== exp_d) begin
          errors++; $display("[TB] FAIL tie_read_data got %h want %h", fb.rd_resp_data, exp_d);
        end
        got_order.push_back(1'b1);
        nr++;
        if (nr < 2) fb.rd_req_addr = ra[nr];
        else fb.rd_req = 1'b0;
      end
    end
    fb.wr_req = 1'b0; fb.rd_req = 1'b0;
    checks++;
    if (got_order.size() != 4) begin
      errors++; $display("[TB] FAIL tie_count got %0d acks want 4", got_order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_order[i] !== exp_order[i]) begin
          errors++; $display("[TB] FAIL tie_order slot %0d got %s want %s", i,
                             got_order[i] ? "R" : "W", exp_order[i] ? "R" : "W");
        end
      end
    end
    checks++;
    if (overlap_cnt != 0 || dual_ack_cnt != 0) begin
      errors++; $display("[TB] FAIL tie_exclusive overlap %0d dual_ack %0d want 0 0", overlap_cnt, dual_ack_cnt);
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, en, acks; bit ok; logic [DW-1:0] d;
    d = $urandom;
    @(negedge clk);
    fb.wr_req = 1'b1; fb.wr_req_addr = 29'h3F; fb.wr_req_data = d;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (fb.mem_wr_en !== 1'b0) begin
      errors++; $display("[TB] FAIL midwrite_en got %b want 0", fb.mem_wr_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({fb.mem_wr_en, fb.busy, fb.wr_ack} !== 3'b100 || fb.mem_wr_addr !== '0 || fb.mem_wr_data !== '0) begin
      errors++; $display("[TB] FAIL async_reset got en/busy/ack %b addr %h data %h want 100 0 0",
                         {fb.mem_wr_en, fb.busy, fb.wr_ack}, fb.mem_wr_addr, fb.mem_wr_data);
    end
    fb.wr_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (fb.wr_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0 || fb.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL aborted_write acks %0d busy %b want 0 0", acks, fb.busy);
    end
    do_write(29'h3F, d, lat, en, ok);
    checks++;
    if (lat != CMDC + 1 || en != CMDC || !ok) begin
      errors++; $display("[TB] FAIL reissue_write lat %0d en %0d ok %0b want %0d %0d 1", lat, en, ok, CMDC + 1, CMDC);
    end
  endtask

  task automatic test_drop_read;
    int acks, ack_cyc;
    logic [DW-1:0] d, exp_d;
    exp_d = ref_mem[6'h10];
    d = '0;
    @(negedge clk);
    fb.rd_req = 1'b1; fb.rd_req_addr = 29'h10;
    @(negedge clk);
    fb.rd_req = 1'b0;
    acks = 0; ack_cyc = 0;
    for (int c = 2; c < 16; c++) begin
      @(negedge clk);
      if (fb.rd_ack === 1'b1) begin
        acks++; ack_cyc = c; d = fb.rd_resp_data;
      end
    end
    checks++;
    if (acks != 1 || ack_cyc != CMDC + 2) begin
      errors++; $display("[TB] FAIL drop_read acks %0d at cycle %0d want 1 at %0d", acks, ack_cyc, CMDC + 2);
    end
    checks++;
    if (d !== exp_d) begin
      errors++; $display("[TB] FAIL drop_read_data got %h want %h", d, exp_d);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      stub_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    fb.wr_req = 1'b0; fb.wr_req_addr = '0; fb.wr_req_data = '0;
    fb.rd_req = 1'b0; fb.rd_req_addr = '0;
    test_reset();
    test_single_write();
    test_write_read();
    test_random();
    test_tie();
    test_reset_mid_write();
    test_drop_read();
    checks++;
    if (overlap_cnt != 0 || dual_ack_cnt != 0) begin
      errors++; $display("[TB] FAIL global_exclusive overlap %0d dual_ack %0d want 0 0", overlap_cnt, dual_ack_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
